pc_flags_unit: RTL and testbench

- Sits directly upstream of the control FSM.
- Holds the architectural program counter and the processor status flags (C, L, F, Z, N).
- Evaluates CR16-style branch/jump conditions and supplies the FSM with pc_in and the instruction-memory fetch address.
- Advances, branches or jumps only when the FSM asserts pc_en, and latches ALU flags when the FSM asserts alu_flags_en.

---
 rtl/pc_flags_unit.sv | 119 +++++++++++
 tb/tb_pc_flags_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_flags_unit.sv
// Program counter and status-flag register slice feeding the control FSM.
// Evaluates the CR16 branch condition codes against the registered flags.
module pc_flags_unit #(
  parameter int                     PC_WIDTH = 16,
  parameter int                     IMEM_AW  = 9,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_en,
  input  logic [1:0]          pc_mode,
  input  logic [3:0]          cond,
  input  logic [7:0]          disp,
  input  logic [PC_WIDTH-1:0] jmp_target,
  input  logic                alu_flags_en,
  input  logic [4:0]          alu_flags_sel,
  input  logic [4:0]          alu_flags,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [IMEM_AW-1:0]  imem_addr,
  output logic [PC_WIDTH-1:0] link_addr,
  output logic [4:0]          flags,
  output logic                taken
);

  localparam logic [1:0] MODE_INC  = 2'b00;
  localparam logic [1:0] MODE_BRA  = 2'b01;
  localparam logic [1:0] MODE_JMP  = 2'b10;

  logic [PC_WIDTH-1:0]        pc_q, pc_d;
  logic [4:0]                 flags_q, flags_d;
  logic                       taken_q, taken_d;
  logic [PC_WIDTH-1:0]        pc_inc;
  logic signed [PC_WIDTH-1:0] disp_ext;
  logic                       cond_ok;

  // Flag order is {N,Z,F,L,C}.
  function automatic logic cond_eval(input logic [3:0] c, input logic [4:0] f);
    logic n, z, fl, l, cy;
    n  = f[4];
    z  = f[3];
    fl = f[2];
    l  = f[1];
    cy = f[0];
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = cy;
      4'b0011: cond_eval = ~cy;
      4'b0100: cond_eval = l;
      4'b0101: cond_eval = ~l;
      4'b0110: cond_eval = n;
      4'b0111: cond_eval = ~n;
      4'b1000: cond_eval = fl;
      4'b1001: cond_eval = ~fl;
      4'b1010: cond_eval = ~l & ~z;
      4'b1011: cond_eval = l | z;
      4'b1100: cond_eval = ~n & ~z;
      4'b1101: cond_eval = n | z;
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign pc_inc   = pc_q + PC_WIDTH'(1);
  assign disp_ext = {{(PC_WIDTH-8){disp[7]}}, disp};
  // Conditions see the registered flags, so a same-cycle flag write is not visible yet.
  assign cond_ok  = cond_eval(cond, flags_q);

  always_comb begin
    pc_d    = pc_q;
    taken_d = taken_q;
    if (pc_en) begin
      case (pc_mode)
        MODE_INC: begin
          pc_d    = pc_inc;
          taken_d = 1'b0;
        end
        MODE_BRA: begin
          pc_d    = cond_ok ? pc_q + disp_ext : pc_inc;
          taken_d = cond_ok;
        end
        MODE_JMP: begin
          pc_d    = cond_ok ? jmp_target : pc_inc;
          taken_d = cond_ok;
        end
        default: begin
          pc_d    = pc_q;
          taken_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (alu_flags_en) begin
      flags_d = (flags_q & ~alu_flags_sel) | (alu_flags & alu_flags_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      flags_q <= 5'b0;
      taken_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      taken_q <= taken_d;
    end
  end

  assign pc_out    = pc_q;
  assign imem_addr = pc_q[IMEM_AW-1:0];
  assign link_addr = pc_inc;
  assign flags     = flags_q;
  assign taken     = taken_q;

endmodule

// File: tb/tb_pc_flags_unit.sv
// Directed vector table followed by randomized traffic against a behavioural model.
module tb_pc_flags_unit;

  logic        clk = 1'b0;
  logic        rst, pc_en, alu_flags_en;
  logic [1:0]  pc_mode;
  logic [3:0]  cond;
  logic [7:0]  disp;
  logic [15:0] jmp_target;
  logic [4:0]  alu_flags_sel, alu_flags;
  logic [15:0] pc_out, link_addr;
  logic [8:0]  imem_addr;
  logic [4:0]  flags;
  logic        taken;

  int n_vec = 0;
  int n_bad = 0;

  pc_flags_unit #(.PC_WIDTH(16), .IMEM_AW(9), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .pc_mode(pc_mode), .cond(cond),
    .disp(disp), .jmp_target(jmp_target), .alu_flags_en(alu_flags_en),
    .alu_flags_sel(alu_flags_sel), .alu_flags(alu_flags), .pc_out(pc_out),
    .imem_addr(imem_addr), .link_addr(link_addr), .flags(flags), .taken(taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit        pc_en;
    bit [1:0]  mode;
    bit [3:0]  cond;
    bit [7:0]  disp;
    bit [15:0] jt;
    bit        fen;
    bit [4:0]  fsel;
    bit [4:0]  fval;
    bit [15:0] exp_pc;
    bit [4:0]  exp_flags;
    bit        exp_taken;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference state.
  int m_pc;
  bit m_n, m_z, m_f, m_l, m_c;
  bit m_taken;

  function automatic vec_t mk(bit r, bit en, bit [1:0] md, bit [3:0] c, bit [7:0] d,
                              bit [15:0] jt, bit fe, bit [4:0] fs, bit [4:0] fv,
                              bit [15:0] ep, bit [4:0] ef, bit et);
    vec_t v;
    v.rst = r; v.pc_en = en; v.mode = md; v.cond = c; v.disp = d; v.jt = jt;
    v.fen = fe; v.fsel = fs; v.fval = fv;
    v.exp_pc = ep; v.exp_flags = ef; v.exp_taken = et;
    return v;
  endfunction

  task automatic drive(bit r, bit en, bit [1:0] md, bit [3:0] c, bit [7:0] d,
                       bit [15:0] jt, bit fe, bit [4:0] fs, bit [4:0] fv);
    rst = r; pc_en = en; pc_mode = md; cond = c; disp = d; jmp_target = jt;
    alu_flags_en = fe; alu_flags_sel = fs; alu_flags = fv;
  endtask

  task automatic check(string nm, bit [15:0] epc, bit [4:0] ef, bit et);
    bit [15:0] elink;
    bit [8:0]  eimem;
    elink = epc + 16'd1;
    eimem = epc[8:0];
    n_vec++;
    if (pc_out !== epc || flags !== ef || taken !== et ||
        imem_addr !== eimem || link_addr !== elink) begin
      n_bad++;
      $display("FAIL %s: got pc=%h flags=%b taken=%b imem=%h link=%h, expected pc=%h flags=%b taken=%b imem=%h link=%h",
               nm, pc_out, flags, taken, imem_addr, link_addr, epc, ef, et, eimem, elink);
    end
  endtask

  function automatic bit model_cond(bit [3:0] c);
    case (c)
      0:  return m_z == 1;
      1:  return m_z == 0;
      2:  return m_c == 1;
      3:  return m_c == 0;
      4:  return m_l == 1;
      5:  return m_l == 0;
      6:  return m_n == 1;
      7:  return m_n == 0;
      8:  return m_f == 1;
      9:  return m_f == 0;
      10: return m_l == 0 && m_z == 0;
      11: return m_l == 1 || m_z == 1;
      12: return m_n == 0 && m_z == 0;
      13: return m_n == 1 || m_z == 1;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(bit r, bit en, bit [1:0] md, bit [3:0] c, bit [7:0] d,
                            bit [15:0] jt, bit fe, bit [4:0] fs, bit [4:0] fv);
    bit ok;
    int off;
    if (r) begin
      m_pc = 0; {m_n, m_z, m_f, m_l, m_c} = 5'b0; m_taken = 0;
      return;
    end
    ok  = model_cond(c);
    off = (d >= 128) ? int'(d) - 256 : int'(d);
    if (en) begin
      case (md)
        0: begin m_pc = (m_pc + 1) % 65536; m_taken = 0; end
        1: begin m_pc = ok ? (m_pc + off + 65536) % 65536 : (m_pc + 1) % 65536; m_taken = ok; end
        2: begin m_pc = ok ? int'(jt) : (m_pc + 1) % 65536; m_taken = ok; end
        default: m_taken = 0;
      endcase
    end
    if (fe) begin
      if (fs[4]) m_n = fv[4];
      if (fs[3]) m_z = fv[3];
      if (fs[2]) m_f = fv[2];
      if (fs[1]) m_l = fv[1];
      if (fs[0]) m_c = fv[0];
    end
  endtask

  initial begin
    //        rst en md  cond   disp   jt        fe sel      val      exp_pc    flags    t
    vecs.push_back(mk(1, 1, 0, 4'h0, 8'h00, 16'h0000, 0, 5'b00000, 5'b00000, 16'h0000, 5'b00000, 0));
    vecs.push_back(mk(1, 1, 0, 4'h0, 8'h00, 16'h0000, 0, 5'b00000, 5'b00000, 16'h0000, 5'b00000, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 8'h00, 16'h0000, 0, 5'b00000, 5'b00000, 16'h0001, 5'b00000, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 8'h00, 16'h0000, 0, 5'b00000, 5'b00000, 16'h0002, 5'b00000, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 8'h00, 16'h0000, 0, 5'b00000, 5'b00000, 16'h0003, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 16'h0000, 1, 5'b01000, 5'b01000, 16'h0003, 5'b01000, 0));
    vecs.push_back(mk(0, 1, 2, 4'hE, 8'h00, 16'h0010, 0, 5'b00000, 5'b00000, 16'h0010, 5'b01000, 1));
    vecs.push_back(mk(0, 1, 1, 4'h0, 8'hFC, 16'h0000, 0, 5'b00000, 5'b00000, 16'h000C, 5'b01000, 1));
    vecs.push_back(mk(0, 1, 1, 4'h1, 8'hFC, 16'h0000, 0, 5'b00000, 5'b00000, 16'h000D, 5'b01000, 0));
    vecs.push_back(mk(0, 1, 2, 4'hE, 8'h00, 16'h1234, 0, 5'b00000, 5'b00000, 16'h1234, 5'b01000, 1));
    vecs.push_back(mk(0, 1, 2, 4'hF, 8'h00, 16'h5555, 0, 5'b00000, 5'b00000, 16'h1235, 5'b01000, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 16'h0000, 1, 5'b11111, 5'b00000, 16'h1235, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 16'h0000, 1, 5'b00001, 5'b11111, 16'h1235, 5'b00001, 0));
    vecs.push_back(mk(0, 1, 2, 4'hE, 8'h00, 16'h0020, 0, 5'b00000, 5'b00000, 16'h0020, 5'b00001, 1));
    vecs.push_back(mk(0, 1, 1, 4'h0, 8'h05, 16'h0000, 1, 5'b01000, 5'b01000, 16'h0021, 5'b01001, 0));
    vecs.push_back(mk(0, 1, 1, 4'h0, 8'h05, 16'h0000, 0, 5'b00000, 5'b00000, 16'h0026, 5'b01001, 1));
    vecs.push_back(mk(0, 1, 2, 4'hE, 8'h00, 16'hFFFF, 0, 5'b00000, 5'b00000, 16'hFFFF, 5'b01001, 1));
    vecs.push_back(mk(0, 1, 0, 4'hE, 8'h00, 16'h0000, 0, 5'b00000, 5'b00000, 16'h0000, 5'b01001, 0));
    vecs.push_back(mk(0, 1, 1, 4'hE, 8'hFF, 16'h0000, 0, 5'b00000, 5'b00000, 16'hFFFF, 5'b01001, 1));
    vecs.push_back(mk(0, 0, 0, 4'hE, 8'h10, 16'h4444, 0, 5'b00000, 5'b00000, 16'hFFFF, 5'b01001, 1));
    vecs.push_back(mk(0, 0, 1, 4'hE, 8'h10, 16'h4444, 0, 5'b00000, 5'b00000, 16'hFFFF, 5'b01001, 1));
    vecs.push_back(mk(0, 0, 2, 4'hE, 8'h10, 16'h4444, 0, 5'b00000, 5'b00000, 16'hFFFF, 5'b01001, 1));
    vecs.push_back(mk(0, 0, 3, 4'hE, 8'h10, 16'h4444, 0, 5'b00000, 5'b00000, 16'hFFFF, 5'b01001, 1));
    vecs.push_back(mk(0, 1, 3, 4'hE, 8'h10, 16'h4444, 0, 5'b00000, 5'b00000, 16'hFFFF, 5'b01001, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 8'h00, 16'h0000, 0, 5'b00000, 5'b00000, 16'h0000, 5'b01001, 0));
    vecs.push_back(mk(0, 1, 2, 4'hE, 8'h00, 16'h0ABC, 1, 5'b10110, 5'b10100, 16'h0ABC, 5'b11101, 1));
    vecs.push_back(mk(1, 1, 2, 4'hE, 8'h00, 16'h1111, 1, 5'b11111, 5'b11111, 16'h0000, 5'b00000, 0));

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pc_en, vecs[i].mode, vecs[i].cond, vecs[i].disp,
            vecs[i].jt, vecs[i].fen, vecs[i].fsel, vecs[i].fval);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_flags, vecs[i].exp_taken);
    end

    m_pc = 0; {m_n, m_z, m_f, m_l, m_c} = 5'b0; m_taken = 0;
    for (int k = 0; k < 3000; k++) begin
      bit        r, en, fe;
      bit [1:0]  md;
      bit [3:0]  c;
      bit [7:0]  d;
      bit [15:0] jt;
      bit [4:0]  fs, fv;
      r  = ($urandom_range(0, 63) == 0);
      en = ($urandom_range(0, 3) != 0);
      md = 2'($urandom_range(0, 3));
      c  = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      jt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      fe = ($urandom_range(0, 2) == 0);
      fs = 5'($urandom);
      fv = 5'($urandom);
      drive(r, en, md, c, d, jt, fe, fs, fv);
      model_step(r, en, md, c, d, jt, fe, fs, fv);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", k), 16'(m_pc), {m_n, m_z, m_f, m_l, m_c}, m_taken);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
